// File: rtl/axil_reg_access_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between two
// register-access requesters; one single-beat read or write in flight at a time.
module axil_reg_access_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [DATA_WIDTH-1:0]   wdata0,
  input  logic [DATA_WIDTH-1:0]   wdata1,
  output logic [1:0]              done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              resp,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_e;

  state_e                  state_q;
  logic                    grant_q;
  logic                    last_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;
  logic [1:0]              done_q;
  logic                    busy_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    grant_d;
  logic                    aw_ok;
  logic                    w_ok;
  logic [ADDR_WIDTH-1:0]   addr_aligned;

  // Round-robin choice: a lone requester wins, on contention the one not granted last wins
  always_comb begin
    grant_d = req[1];
    if (req == 2'b11) grant_d = ~last_q;
  end

  // A channel counts as finished once its valid has dropped or is handshaking now
  assign aw_ok        = ~awvalid_q | m_axi_awready;
  assign w_ok         = ~wvalid_q  | m_axi_wready;
  assign addr_aligned = addr_q & ~ADDR_WIDTH'(3);

  assign m_axi_awaddr  = addr_aligned;
  assign m_axi_araddr  = addr_aligned;
  assign m_axi_awprot  = '0;
  assign m_axi_arprot  = '0;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign resp          = resp_q;
  assign busy          = busy_q;

  // Transaction FSM with all bus and requester outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            grant_q <= grant_d;
            last_q  <= grant_d;
            busy_q  <= 1'b1;
            addr_q  <= grant_d ? addr1 : addr0;
            wdata_q <= grant_d ? wdata1 : wdata0;
            if (we[grant_d]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RADDR;
            end
          end
        end
        WADDR: begin
          if (m_axi_awready) awvalid_q <= 1'b0;
          if (m_axi_wready)  wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state_q  <= WRESP;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            bready_q        <= 1'b0;
            resp_q          <= m_axi_bresp;
            done_q[grant_q] <= 1'b1;
            busy_q          <= 1'b0;
            state_q         <= DONE;
          end
        end
        RADDR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            rready_q        <= 1'b0;
            rdata_q         <= m_axi_rdata;
            resp_q          <= m_axi_rresp;
            done_q[grant_q] <= 1'b1;
            busy_q          <= 1'b0;
            state_q         <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_access_arbiter.sv
// Bench for axil_reg_access_arbiter: behavioural AXI4-Lite register slave,
// table of single transactions, then contention, skew, error and reset sequences.
module tb_axil_reg_access_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    req, we, done, resp;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1, rdata;
  logic          busy;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, s_rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clock = ~clock;

  axil_reg_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .rdata(rdata), .resp(resp), .busy(busy),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(s_rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [31:0]   regs [4];
  int            aw_dly = 0;
  int            aw_cnt;
  logic          b_hold = 1'b0;
  logic          have_aw, have_w, aw_got, w_got;
  logic [AW-1:0] s_waddr, a_eff;
  logic [31:0]   s_wdata, d_eff;

  assign awready = awvalid && (aw_cnt == aw_dly);
  assign wready  = wvalid;
  assign arready = arvalid;
  assign aw_got  = have_aw || (awvalid && awready);
  assign w_got   = have_w  || (wvalid && wready);
  assign a_eff   = have_aw ? s_waddr : awaddr;
  assign d_eff   = have_w  ? s_wdata : wdata;

  function automatic logic [1:0] s_resp(input logic [AW-1:0] a);
    return (a > AW'(12)) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      aw_cnt <= 0; have_aw <= 1'b0; have_w <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; s_rdata <= '0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1; else aw_cnt <= 0;
      if (aw_got && w_got && !bvalid && !b_hold) begin
        if (a_eff <= AW'(12)) regs[a_eff[3:2]] <= d_eff;
        bresp   <= s_resp(a_eff);
        bvalid  <= 1'b1;
        have_aw <= 1'b0;
        have_w  <= 1'b0;
      end else begin
        if (awvalid && awready) begin have_aw <= 1'b1; s_waddr <= awaddr; end
        if (wvalid && wready)   begin have_w  <= 1'b1; s_wdata <= wdata;  end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid  <= 1'b1;
        s_rdata <= (araddr <= AW'(12)) ? regs[araddr[3:2]] : 32'hDEAD_BEEF;
        rresp   <= s_resp(araddr);
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- protocol monitor ----------------
  logic          rst_at_edge = 1'b1;
  logic          p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [31:0]   p_wdata;

  always @(posedge clock) rst_at_edge <= reset;

  always @(negedge clock) begin
    if (!rst_at_edge) begin
      if (p_aw && (!awvalid || awaddr !== p_awaddr)) begin
        errs++; $display("FAIL aw_hold: awvalid=%0b awaddr=0x%0h, required 1/0x%0h", awvalid, awaddr, p_awaddr);
      end
      if (p_w && (!wvalid || wdata !== p_wdata)) begin
        errs++; $display("FAIL w_hold: wvalid=%0b wdata=0x%0h, required 1/0x%0h", wvalid, wdata, p_wdata);
      end
      if (p_ar && (!arvalid || araddr !== p_araddr)) begin
        errs++; $display("FAIL ar_hold: arvalid=%0b araddr=0x%0h, required 1/0x%0h", arvalid, araddr, p_araddr);
      end
      if (awprot !== 3'b000 || arprot !== 3'b000) begin
        errs++; $display("FAIL prot: awprot=%0d arprot=%0d, required 0", awprot, arprot);
      end
    end
    if (done === 2'b11) begin
      errs++; $display("FAIL done_onehot: done=%b, required at most one bit", done);
    end
    p_aw = awvalid && !awready; p_awaddr = awaddr;
    p_w  = wvalid && !wready;   p_wdata  = wdata;
    p_ar = arvalid && !arready; p_araddr = araddr;
  end

  // ---------------- single-transaction driver ----------------
  logic          obs_seen, obs_busy1, obs_done_after, obs_busy_after;
  int            obs_lat, obs_awv, obs_wv, obs_bhs;
  logic [1:0]    obs_done, obs_resp;
  logic [31:0]   obs_rdata, obs_wdata;
  logic [AW-1:0] obs_awaddr;
  logic [3:0]    obs_wstrb;

  // Called at a negedge with the DUT idle; returns one cycle after done
  task automatic run_txn(input int id, input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    obs_seen = 1'b0; obs_lat = 0; obs_awv = 0; obs_wv = 0; obs_bhs = 0; obs_busy1 = 1'b0;
    obs_done = '0; obs_resp = '0; obs_rdata = '0; obs_wdata = '0; obs_awaddr = '0; obs_wstrb = '0;
    if (id == 0) begin addr0 = a; wdata0 = d; end else begin addr1 = a; wdata1 = d; end
    we[id]  = w;
    req[id] = 1'b1;
    for (int k = 1; k <= 50 && !obs_seen; k++) begin
      @(negedge clock);
      if (k == 1) obs_busy1 = busy;
      if (awvalid) obs_awv++;
      if (wvalid)  obs_wv++;
      if (awvalid && awready) obs_awaddr = awaddr;
      if (wvalid && wready) begin obs_wdata = wdata; obs_wstrb = wstrb; end
      if (bvalid && bready) obs_bhs++;
      if (done != 2'b00) begin
        obs_seen = 1'b1; obs_lat = k + 1; obs_done = done; obs_rdata = rdata; obs_resp = resp;
      end
    end
    req[id] = 1'b0;
    @(negedge clock);
    obs_done_after = |done;
    obs_busy_after = busy;
    chk("done_within_budget", 32'(obs_seen), 32'd1);
  endtask

  typedef struct {
    int            id;
    logic          w;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [AW-1:0] exp_awaddr;
    logic [31:0]   exp_rdata;
    logic [1:0]    exp_resp;
  } vec_t;

  vec_t tbl [10];
  int   order [4];
  logic [31:0] ord_data [4];
  int   nd;

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valids"}, 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
    chk({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_resp"}, 32'(resp), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clock);
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clock);

    // id, w, addr, wdata, expected awaddr, expected rdata, expected resp
    tbl[0] = '{0, 1'b1, 5'h00, 32'h1,  5'h00, 32'h0,  2'b00};
    tbl[1] = '{0, 1'b1, 5'h04, 32'h2,  5'h04, 32'h0,  2'b00};
    tbl[2] = '{0, 1'b1, 5'h08, 32'h3,  5'h08, 32'h0,  2'b00};
    tbl[3] = '{0, 1'b1, 5'h0C, 32'h4,  5'h0C, 32'h0,  2'b00};
    tbl[4] = '{1, 1'b0, 5'h00, 32'h0,  5'h00, 32'h1,  2'b00};
    tbl[5] = '{1, 1'b0, 5'h04, 32'h0,  5'h00, 32'h2,  2'b00};
    tbl[6] = '{1, 1'b0, 5'h08, 32'h0,  5'h00, 32'h3,  2'b00};
    tbl[7] = '{1, 1'b0, 5'h0C, 32'h0,  5'h00, 32'h4,  2'b00};
    tbl[8] = '{0, 1'b1, 5'h07, 32'h55, 5'h04, 32'h0,  2'b00};
    tbl[9] = '{1, 1'b0, 5'h05, 32'h0,  5'h00, 32'h55, 2'b00};

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].id, tbl[i].w, tbl[i].a, tbl[i].d);
      chk($sformatf("v%0d_done", i), 32'(obs_done), 32'(2'b01 << tbl[i].id));
      chk($sformatf("v%0d_latency", i), 32'(obs_lat), 32'd4);
      chk($sformatf("v%0d_busy", i), 32'(obs_busy1), 32'd1);
      chk($sformatf("v%0d_resp", i), 32'(obs_resp), 32'(tbl[i].exp_resp));
      chk($sformatf("v%0d_done_once", i), 32'(obs_done_after), 32'd0);
      chk($sformatf("v%0d_idle_busy", i), 32'(obs_busy_after), 32'd0);
      if (tbl[i].w) begin
        chk($sformatf("v%0d_aw_beats", i), 32'(obs_awv), 32'd1);
        chk($sformatf("v%0d_awaddr", i), 32'(obs_awaddr), 32'(tbl[i].exp_awaddr));
        chk($sformatf("v%0d_wdata", i), obs_wdata, tbl[i].d);
        chk($sformatf("v%0d_wstrb", i), 32'(obs_wstrb), 32'hF);
      end else begin
        chk($sformatf("v%0d_rdata", i), obs_rdata, tbl[i].exp_rdata);
      end
    end

    // Contention: both reading, held high throughout
    we = 2'b00; addr0 = 5'h00; addr1 = 5'h08; req = 2'b11;
    nd = 0;
    for (int k = 0; k < 100 && nd < 4; k++) begin
      @(negedge clock);
      if (done != 2'b00) begin
        order[nd]    = (done == 2'b10) ? 1 : 0;
        ord_data[nd] = rdata;
        nd++;
      end
    end
    req = 2'b00;
    chk("contend_count", 32'(nd), 32'd4);
    for (int i = 0; i < nd; i++) begin
      chk($sformatf("contend_grant%0d", i), 32'(order[i]), 32'(i % 2));
      chk($sformatf("contend_rdata%0d", i), ord_data[i], (i % 2 == 0) ? 32'h1 : 32'h3);
    end
    @(negedge clock);

    // Skewed write: AWREADY on the third cycle of AWVALID, WREADY at once
    aw_dly = 2;
    run_txn(0, 1'b1, 5'h08, 32'hAB);
    aw_dly = 0;
    chk("skew_awvalid_cycles", 32'(obs_awv), 32'd3);
    chk("skew_wvalid_cycles", 32'(obs_wv), 32'd1);
    chk("skew_b_handshakes", 32'(obs_bhs), 32'd1);
    chk("skew_done", 32'(obs_done), 32'b01);
    chk("skew_awaddr", 32'(obs_awaddr), 32'h08);

    // Error response on an out-of-range read
    run_txn(0, 1'b0, 5'h10, 32'h0);
    chk("err_resp", 32'(obs_resp), 32'b10);
    chk("err_done", 32'(obs_done), 32'b01);
    chk("err_idle", 32'({busy, arvalid, rready}), 32'd0);

    // Reset while waiting in WRESP, after a grant to requester 0
    b_hold = 1'b1;
    we = 2'b01; addr0 = 5'h0C; wdata0 = 32'h77; req = 2'b01;
    nd = 0;
    for (int k = 0; k < 50 && nd == 0; k++) begin
      @(negedge clock);
      if (bready) nd = 1;
    end
    chk("rst_reached_wresp", 32'(nd), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_state("midrst");
    reset = 1'b0; b_hold = 1'b0;
    we = 2'b00; addr0 = 5'h00; addr1 = 5'h04; req = 2'b11;
    @(negedge clock);
    chk("post_rst_arvalid", 32'(arvalid), 32'd1);
    chk("post_rst_awvalid", 32'(awvalid), 32'd0);
    nd = 0;
    for (int k = 0; k < 50 && nd == 0; k++) begin
      @(negedge clock);
      if (done != 2'b00) begin
        nd = 1;
        chk("post_rst_first_grant", 32'(done), 32'b01);
        chk("post_rst_rdata", rdata, 32'h1);
      end
    end
    chk("post_rst_done_seen", 32'(nd), 32'd1);
    req = 2'b00;
    repeat (4) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
